// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit-side arbitration logic.
//   arb_state_t      : arbiter FSM state (IDLE, HDR, DATA)
//   ID_HDR_BASE      : upper nibble of the optional per-packet ID header byte
//   UART_NUM_REQ_MAX : largest supported requester count
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [7:0] ID_HDR_BASE      = 8'hA0;
    localparam int         UART_NUM_REQ_MAX = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches ptr+1, ptr+2, ... (mod N) and
// returns the first requester with its bit set. Built as rotate, priority
// encode, un-rotate so it can be reused by other bus arbiters.
// Ports:
//   req     [N-1:0] : request vector
//   ptr     [W-1:0] : index of the last winner (search starts one past it)
//   gnt_idx [W-1:0] : index of the selected requester (0 when none)
//   any             : at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         any
);

    // w_src[k] is the original requester index sitting at rotated slot k;
    // it serves both the rotate and the un-rotate.
    logic [W-1:0] w_src [N];
    logic [N-1:0] w_rot;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign w_src[gi] = W'((int'(ptr) + gi + 1) % N);
            assign w_rot[gi] = req[w_src[gi]];
        end
    endgenerate

    // Lowest rotated slot wins; scanning downward lets the last hit stand.
    always_comb begin
        gnt_idx = '0;
        any     = |w_rot;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                gnt_idx = w_src[i];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Packet-level round-robin arbiter sharing one UART transmitter among
// NUM_REQ byte-stream requesters. A grant is held from a packet's first byte
// through its req_last byte, so packets never interleave on the line.
// Optional feature macro: UART_ARB_ID_HEADER_EN -- when defined, every packet
// is prefixed by one header byte ID_HDR_BASE | grant_id.
// Ports:
//   clk                  : system clock
//   rst_n                : synchronous active-low reset
//   req_valid [NUM_REQ]  : per-requester byte valid
//   req_data  [8*NUM_REQ]: requester i byte at [8*i+7:8*i]
//   req_last  [NUM_REQ]  : final byte of a packet (qualified by req_valid)
//   req_ready [NUM_REQ]  : per-requester accept, at most one bit high
//   tx_data   [8]        : byte to the transmitter
//   tx_valid             : byte valid to the transmitter
//   tx_ready             : transmitter accepts the byte
//   grant_id  [GRANT_W]  : current owner, holds last value while idle
//   busy                 : registered, high while not IDLE
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GRANT_W = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*8-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [GRANT_W-1:0]     grant_id,
    output logic                   busy
);

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [GRANT_W-1:0] r_ptr;
    logic [GRANT_W-1:0] w_ptr_next;
    logic [GRANT_W-1:0] r_grant;
    logic [GRANT_W-1:0] w_grant_next;
    logic               r_busy;

    logic [GRANT_W-1:0] w_pick;
    logic               w_any;
    logic [7:0]         w_bytes [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign w_bytes[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    rr_pick #(
        .N (NUM_REQ),
        .W (GRANT_W)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (r_ptr),
        .gnt_idx (w_pick),
        .any     (w_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= GRANT_W'(NUM_REQ - 1);
            r_grant <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_grant <= w_grant_next;
            r_busy  <= (w_state_next != IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_grant_next = r_grant;
        tx_valid     = 1'b0;
        tx_data      = '0;
        req_ready    = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_next = w_pick;
`ifdef UART_ARB_ID_HEADER_EN
                    w_state_next = HDR;
`else
                    w_state_next = DATA;
`endif
                end
            end
`ifdef UART_ARB_ID_HEADER_EN
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = ID_HDR_BASE | 8'(r_grant);
                if (tx_ready) begin
                    w_state_next = DATA;
                end
            end
`endif
            DATA: begin
                // Straight pass-through from the owner; no extra register stage.
                tx_valid           = req_valid[r_grant];
                tx_data            = w_bytes[r_grant];
                req_ready[r_grant] = tx_ready;
                if (req_valid[r_grant] && tx_ready && req_last[r_grant]) begin
                    w_state_next = IDLE;
                    w_ptr_next   = r_grant;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign grant_id = r_grant;
    assign busy     = r_busy;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single `uart_transmitter` between `NUM_REQ` byte-stream requesters, for example a debug console, a bootloader ACK path and a CPU MMIO port. It sits between the requesters and the transmitter's ready/valid input. A grant is held from a packet's first byte through its `req_last` byte, so packets from different requesters never interleave on the serial line.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `GRANT_W`, `$clog2(NUM_REQ)`, derived width of the grant index; not to be overridden.

Ports:
- `clk` input 1: single system clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `req_valid` input `NUM_REQ`: per-requester byte valid.
- `req_data` input `NUM_REQ*8`: requester i byte is at `[8*i+7:8*i]`.
- `req_last` input `NUM_REQ`: marks the final byte of a packet; qualified by `req_valid`.
- `req_ready` output `NUM_REQ`: per-requester accept; at most one bit is high at any time.
- `tx_data` output 8: byte to the transmitter.
- `tx_valid` output 1: byte valid to the transmitter.
- `tx_ready` input 1: transmitter accepts the byte.
- `grant_id` output `GRANT_W`: index of the current owner; holds its last value while in IDLE.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- FSM states are IDLE, HDR and DATA. HDR exists only when the header feature is compiled in.
- IDLE:
  - `tx_valid`=0 and `req_ready`=0.
  - If any `req_valid` is high, pick the first requester with valid high, searching `ptr+1, ptr+2, …` with wrap modulo `NUM_REQ`.
  - Register the winner into `grant_id`.
  - Go to HDR if the header feature is enabled, otherwise go to DATA.
- HDR:
  - Drive `tx_data`=`ID_HDR_BASE | grant_id` and `tx_valid`=1.
  - `req_ready`=0.
  - On `tx_valid && tx_ready`, go to DATA.
- DATA:
  - Combinational pass-through from the owner g: `tx_valid`=`req_valid[g]`, `tx_data`=`req_data[g]`, `req_ready[g]`=`tx_ready`.
  - All other `req_ready` bits are 0.
  - On a handshake with `req_last[g]`=1: go to IDLE and set `ptr`<=g.
- Round-robin pointer `ptr` resets to `NUM_REQ-1`, so requester 0 wins the first arbitration.
- A valid gap from the owner in mid-packet holds the grant with no timeout. `tx_valid` drops during the gap and nothing else changes.
- Valid from non-owners is ignored until the owner's packet ends. Those requesters' ready stays 0.
- A single-byte packet (`req_last` on the first byte) is legal: one byte, then back to IDLE.
- `rst_n` low in any state forces IDLE next cycle. The byte in flight is abandoned; the transmitter may already hold it.
- Reset values:
  - `req_ready`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `grant_id`=0.
  - `ptr`=`NUM_REQ-1`, state=IDLE.

## Timing
- Request to first `tx_valid` latency:
  - 1 cycle: request seen in IDLE, DATA or HDR output the next cycle.
- Packet to packet:
  - Exactly one IDLE cycle between the `req_last` handshake and the next grant.
  - This IDLE cycle occurs even when the same or another requester is already valid.
- In DATA the throughput is one byte per cycle, limited only by `tx_ready`. There is no added register stage.
- `tx_ready` to `req_ready` is a combinational path. Requesters must not make `req_valid` depend on `req_ready`.
- `grant_id` and `busy` are registered and change on the cycle after the FSM transition.

## Configuration
- Macro: `UART_ARB_ID_HEADER_EN`.
- Defined:
  - The HDR state is present.
  - Each packet is prefixed by one byte `8'hA0 | grant_id`.
  - Request to first payload byte is then 2 cycles, plus any `tx_ready` stall.
- Undefined:
  - HDR logic is removed and IDLE goes directly to DATA.
  - The serial stream carries payload bytes only.

## Structure
- `uart_pkg`:
  - FSM state enum `arb_state_t` (IDLE, HDR, DATA).
  - `ID_HDR_BASE`=8'hA0.
  - `UART_NUM_REQ_MAX`=8.
- Sub-module `rr_pick`:
  - Combinational.
  - Inputs: `req` vector and `ptr`. Outputs: `gnt_idx` and `any`.
  - Implemented as a rotate, priority encode, then un-rotate.
  - Reused by later bus arbiters.

## Test plan
- Reset then single request: req0 sends 3 bytes 0x11,0x22,0x33 with last on 0x33 → `tx_data` sequence 0x11,0x22,0x33, `grant_id`=0, `busy` falls 1 cycle after the last handshake.
- Simultaneous request: all 4 requesters hold 2-byte packets continuously → grant order 0,1,2,3,0; no interleaving; exactly 1 idle cycle between packets.
- Backpressure: `tx_ready` toggles every other cycle during a 4-byte packet from req2 → `req_ready[2]` mirrors `tx_ready`; all 4 bytes are delivered in order with no duplicates.
- Mid-packet gap: req1 drops valid for 5 cycles after byte 1 while req3 is valid → grant stays 1; `req_ready[3]`=0 throughout; req3 is served after req1's last byte.
- Reset mid-packet: `rst_n` is pulsed low in DATA while owner=2 → next cycle IDLE, all outputs at reset values; the following arbitration with req0 and req2 both valid grants 0.
- With `UART_ARB_ID_HEADER_EN`: req3 sends 1 byte 0x5A → `tx_data` sequence 0xA3, 0x5A; `req_ready[3]` stays 0 during the header byte.
